// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259A PIC: runs the ICW/OCW1 init
// sequence, run-time mask writes, OCW3 status reads and the two-pulse
// INTA acknowledge, returning vectors and status through handshakes.
module pic_host_sequencer #(
   parameter int WR_PULSE   = 2,
   parameter int INTA_PULSE = 2,
   parameter int INTA_GAP   = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] cfgICW1,
   input  logic [7:0] cfgICW2,
   input  logic [7:0] cfgICW3,
   input  logic [7:0] cfgICW4,
   input  logic [7:0] cfgMask,
   input  logic       initStart,
   input  logic       maskWrite,
   input  logic [7:0] maskData,
   input  logic       statusReq,
   input  logic       statusSel,
   input  logic       picINT,
   input  logic [7:0] picDBusIn,
   output logic [7:0] picDBusOut,
   output logic       picDBusOE,
   output logic       picCS,
   output logic       picWR,
   output logic       picRD,
   output logic       picINTA,
   output logic       picA0,
   output logic [7:0] vector,
   output logic       vectorValid,
   input  logic       vectorReady,
   output logic [7:0] statusData,
   output logic       statusValid,
   output logic       initDone,
   output logic       busy
);

   typedef enum logic [3:0] {
      INIT_ICW1, INIT_ICW2, INIT_ICW3, INIT_ICW4, INIT_OCW1, IDLE, MASK_WR,
      ACK1, ACK_GAP, ACK2, VEC_HOLD, STAT_WR, STAT_RD
   } state_t;

   // Write states start with a recovery cycle (cnt 0) so back-to-back
   // words get CS high between them and the post-reset cycle is quiet.
   localparam logic [7:0] WR_LO_LAST = 8'(WR_PULSE + 1);
   localparam logic [7:0] WR_LAST    = 8'(WR_PULSE + 2);
   localparam logic [7:0] RD_LO_LAST = 8'(WR_PULSE);
   localparam logic [7:0] RD_END     = 8'(WR_PULSE + 1);
   localparam logic [7:0] IP_LAST    = 8'(INTA_PULSE - 1);
   localparam logic [7:0] GAP_LAST   = 8'(INTA_GAP - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] wdata_q, wdata_d;
   logic       maskPend_q, maskPend_d;
   logic [7:0] maskData_q, maskData_d;
   logic       statPend_q, statPend_d;
   logic       statSel_q, statSel_d;
   logic       intS1_q, intS2_q;
   logic [1:0] lock_q, lock_d;
   logic [7:0] vector_q, vector_d;
   logic       vectorValid_q, vectorValid_d;
   logic [7:0] statusData_q, statusData_d;
   logic       statusValid_q, statusValid_d;
   logic       initDone_q, initDone_d;

   // State, handshake and capture registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= INIT_ICW1;
         cnt_q         <= '0;
         wdata_q       <= '0;
         maskPend_q    <= 1'b0;
         maskData_q    <= '0;
         statPend_q    <= 1'b0;
         statSel_q     <= 1'b0;
         intS1_q       <= 1'b0;
         intS2_q       <= 1'b0;
         lock_q        <= '0;
         vector_q      <= '0;
         vectorValid_q <= 1'b0;
         statusData_q  <= '0;
         statusValid_q <= 1'b0;
         initDone_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wdata_q       <= wdata_d;
         maskPend_q    <= maskPend_d;
         maskData_q    <= maskData_d;
         statPend_q    <= statPend_d;
         statSel_q     <= statSel_d;
         intS1_q       <= picINT;
         intS2_q       <= intS1_q;
         lock_q        <= lock_d;
         vector_q      <= vector_d;
         vectorValid_q <= vectorValid_d;
         statusData_q  <= statusData_d;
         statusValid_q <= statusValid_d;
         initDone_q    <= initDone_d;
      end
   end

   // Next-state sequencing, IDLE arbitration and data capture
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 8'd1;
      wdata_d       = wdata_q;
      maskPend_d    = maskPend_q;
      maskData_d    = maskData_q;
      statPend_d    = statPend_q;
      statSel_d     = statSel_q;
      lock_d        = (lock_q != 2'd0) ? lock_q - 2'd1 : 2'd0;
      vector_d      = vector_q;
      vectorValid_d = vectorValid_q && !vectorReady;
      statusData_d  = statusData_q;
      statusValid_d = 1'b0;
      initDone_d    = initDone_q;
      case (state_q)
         INIT_ICW1: begin
            if (cnt_q == 8'd0) wdata_d = cfgICW1 | 8'h10;
            if (cnt_q == WR_LAST) state_d = INIT_ICW2;
         end
         INIT_ICW2: begin
            if (cnt_q == 8'd0) wdata_d = cfgICW2;
            if (cnt_q == WR_LAST) begin
               if (!cfgICW1[1])     state_d = INIT_ICW3;
               else if (cfgICW1[0]) state_d = INIT_ICW4;
               else                 state_d = INIT_OCW1;
            end
         end
         INIT_ICW3: begin
            if (cnt_q == 8'd0) wdata_d = cfgICW3;
            if (cnt_q == WR_LAST) state_d = cfgICW1[0] ? INIT_ICW4 : INIT_OCW1;
         end
         INIT_ICW4: begin
            if (cnt_q == 8'd0) wdata_d = cfgICW4;
            if (cnt_q == WR_LAST) state_d = INIT_OCW1;
         end
         INIT_OCW1: begin
            if (cnt_q == 8'd0) wdata_d = cfgMask;
            if (cnt_q == WR_LAST) begin
               state_d    = IDLE;
               initDone_d = 1'b1;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (initStart) begin
               state_d    = INIT_ICW1;
               initDone_d = 1'b0;
            end else if (maskPend_q) begin
               state_d    = MASK_WR;
               maskPend_d = 1'b0;
            end else if (intS2_q && !vectorValid_q && lock_q == 2'd0) begin
               state_d = ACK1;
            end else if (statPend_q) begin
               state_d    = STAT_WR;
               statPend_d = 1'b0;
            end
         end
         MASK_WR: begin
            if (cnt_q == 8'd0) wdata_d = maskData_q;
            if (cnt_q == WR_LAST) state_d = IDLE;
         end
         ACK1: begin
            if (cnt_q == IP_LAST) state_d = ACK_GAP;
         end
         ACK_GAP: begin
            if (cnt_q == GAP_LAST) state_d = ACK2;
         end
         ACK2: begin
            if (cnt_q == IP_LAST) begin
               vector_d = picDBusIn;
               lock_d   = 2'd3;
               state_d  = VEC_HOLD;
            end
         end
         VEC_HOLD: begin
            vectorValid_d = 1'b1;
            state_d       = IDLE;
         end
         STAT_WR: begin
            if (cnt_q == 8'd0) wdata_d = {7'b0000101, statSel_q};
            if (cnt_q == WR_LAST) state_d = STAT_RD;
         end
         STAT_RD: begin
            if (cnt_q == RD_LO_LAST) statusData_d = picDBusIn;
            if (cnt_q == RD_END) begin
               statusValid_d = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = INIT_ICW1;
      endcase
      if (maskWrite) begin
         maskPend_d = 1'b1;
         maskData_d = maskData;
      end
      if (statusReq) begin
         statPend_d = 1'b1;
         statSel_d  = statusSel;
      end
      if (state_d != state_q) cnt_d = '0;
   end

   // Bus strobe decode from the current state and phase counter
   always_comb begin
      picCS      = 1'b1;
      picWR      = 1'b1;
      picRD      = 1'b1;
      picINTA    = 1'b1;
      picDBusOE  = 1'b0;
      picA0      = 1'b0;
      picDBusOut = 8'h00;
      case (state_q)
         INIT_ICW1, INIT_ICW2, INIT_ICW3, INIT_ICW4, INIT_OCW1, MASK_WR, STAT_WR: begin
            if (cnt_q != 8'd0) begin
               picCS      = 1'b0;
               picDBusOE  = 1'b1;
               picDBusOut = wdata_q;
               picA0      = !(state_q == INIT_ICW1 || state_q == STAT_WR);
               if (cnt_q >= 8'd2 && cnt_q <= WR_LO_LAST) picWR = 1'b0;
            end
         end
         ACK1: picINTA = 1'b0;
         ACK_GAP: begin
            if (cnt_q == GAP_LAST) begin
               picCS = 1'b0;
               picRD = 1'b0;
            end
         end
         ACK2: begin
            picINTA = 1'b0;
            picCS   = 1'b0;
            picRD   = 1'b0;
         end
         STAT_RD: begin
            if (cnt_q <= RD_LO_LAST) picCS = 1'b0;
            if (cnt_q >= 8'd1 && cnt_q <= RD_LO_LAST) picRD = 1'b0;
         end
         default: ;
      endcase
   end

   assign vector      = vector_q;
   assign vectorValid = vectorValid_q;
   assign statusData  = statusData_q;
   assign statusValid = statusValid_q;
   assign initDone    = initDone_q;
   assign busy        = (state_q != IDLE);

endmodule
